// File: rtl/dcache_dm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dcache_dm
// Brief    : Direct-mapped write-through data cache, one-word lines, 1-cycle
//            read hits. Define DCACHE_STAT_EN to add STAT_HIT/STAT_MISS.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_dm #(
    parameter int IDX_W  = 10,
    parameter int ADDR_W = 27
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        OE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WE,
    output logic        HIT,
    output logic        MISS,
    output logic [31:0] RDATA,
    input  logic        FILL_VALID,
    input  logic [31:0] FILL_DATA,
    input  logic        INV,
    output logic        BUSY
`ifdef DCACHE_STAT_EN
    ,
    output logic [31:0] STAT_HIT,
    output logic [31:0] STAT_MISS
`endif
);

    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam int LINES = 1 << IDX_W;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_MISS_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_unused;

    logic               w_accept;
    logic               w_busy;
    logic               w_hit;
    logic               w_miss;
    logic               w_merge;
    logic               w_tag_match;
    logic               w_fill_do;
    logic               w_inv_do;

    logic               r_rd_v;
    logic               r_wr_v;
    logic [IDX_W-1:0]   r_idx;
    logic [TAG_W-1:0]   r_tag;
    logic [31:0]        r_wdata;
    logic [3:0]         r_we;

    logic [IDX_W-1:0]   r_miss_idx;
    logic [TAG_W-1:0]   r_miss_tag;
    logic               r_inv_pend;

    logic [LINES-1:0]   r_valid;
    logic               r_valid_q;
    logic [31:0]        r_data_mem [LINES];
    logic [TAG_W-1:0]   r_tag_mem  [LINES];
    logic [31:0]        r_data_ram;
    logic [TAG_W-1:0]   r_tag_ram;
    logic [31:0]        r_rdata_hold;

    logic               w_dram_we;
    logic [IDX_W-1:0]   w_dram_idx;
    logic [31:0]        w_dram_wdata;
    logic [31:0]        w_merge_data;

    assign w_idx    = ADDR[2+IDX_W-1:2];
    assign w_tag    = ADDR[ADDR_W-1:2+IDX_W];
    assign w_unused = ^{ADDR[31:ADDR_W], ADDR[1:0]};

    // Requests are dropped while busy, including the cycle the miss is flagged.
    assign w_accept = OE && !w_busy;

    // Lookup stage: RAM outputs and the valid snapshot belong to the
    // request registered at the previous edge.
    assign w_tag_match = r_valid_q && (r_tag_ram == r_tag);
    assign w_hit       = r_rd_v && w_tag_match;
    assign w_miss      = r_rd_v && !w_tag_match;
    assign w_merge     = r_wr_v && w_tag_match;

    assign w_inv_do = (r_state == ST_IDLE) && (INV || r_inv_pend);

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_fill_do   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = w_miss;
                if (w_miss) begin
                    w_state_nxt = ST_MISS_WAIT;
                end
            end
            ST_MISS_WAIT: begin
                w_busy = 1'b1;
                if (FILL_VALID) begin
                    w_fill_do   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_rd_v  <= 1'b0;
            r_wr_v  <= 1'b0;
            r_idx   <= '0;
            r_tag   <= '0;
            r_wdata <= '0;
            r_we    <= '0;
        end else begin
            r_rd_v <= w_accept && (WE == 4'b0000);
            r_wr_v <= w_accept && (WE != 4'b0000);
            if (w_accept) begin
                r_idx   <= w_idx;
                r_tag   <= w_tag;
                r_wdata <= WDATA;
                r_we    <= WE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_miss_idx <= '0;
            r_miss_tag <= '0;
            r_inv_pend <= 1'b0;
        end else begin
            if (w_miss) begin
                r_miss_idx <= r_idx;
                r_miss_tag <= r_tag;
            end
            if ((r_state == ST_MISS_WAIT) && INV) begin
                r_inv_pend <= 1'b1;
            end else if (w_inv_do) begin
                r_inv_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        w_merge_data = r_data_ram;
        for (int b = 0; b < 4; b++) begin
            if (r_we[b]) begin
                w_merge_data[8*b +: 8] = r_wdata[8*b +: 8];
            end
        end
    end

    assign w_dram_we    = w_fill_do || w_merge;
    assign w_dram_idx   = w_fill_do ? r_miss_idx : r_idx;
    assign w_dram_wdata = w_fill_do ? FILL_DATA  : w_merge_data;

    // Write-first RAMs: a read of the line being written this edge sees the
    // new word, which gives write-to-read forwarding and ordered merges.
    always_ff @(posedge CLK) begin
        if (w_dram_we) begin
            r_data_mem[w_dram_idx] <= w_dram_wdata;
        end
        if (w_fill_do) begin
            r_tag_mem[r_miss_idx] <= r_miss_tag;
        end
        if (w_dram_we && (w_dram_idx == w_idx)) begin
            r_data_ram <= w_dram_wdata;
        end else begin
            r_data_ram <= r_data_mem[w_idx];
        end
        if (w_fill_do && (r_miss_idx == w_idx)) begin
            r_tag_ram <= r_miss_tag;
        end else begin
            r_tag_ram <= r_tag_mem[w_idx];
        end
    end

    // Valid snapshot is taken before any same-edge invalidate takes effect.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_valid   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            if (w_inv_do) begin
                r_valid <= '0;
            end else if (w_fill_do) begin
                r_valid[r_miss_idx] <= 1'b1;
            end
            r_valid_q <= r_valid[w_idx];
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_rdata_hold <= '0;
        end else if (w_hit) begin
            r_rdata_hold <= r_data_ram;
        end
    end

    assign HIT   = w_hit;
    assign MISS  = w_miss;
    assign RDATA = w_hit ? r_data_ram : r_rdata_hold;
    assign BUSY  = w_busy;

`ifdef DCACHE_STAT_EN
    logic [31:0] r_stat_hit;
    logic [31:0] r_stat_miss;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_stat_hit  <= '0;
            r_stat_miss <= '0;
        end else if (w_inv_do) begin
            r_stat_hit  <= '0;
            r_stat_miss <= '0;
        end else begin
            if (w_hit && (r_stat_hit != 32'hFFFF_FFFF)) begin
                r_stat_hit <= r_stat_hit + 32'd1;
            end
            if (w_miss && (r_stat_miss != 32'hFFFF_FFFF)) begin
                r_stat_miss <= r_stat_miss + 32'd1;
            end
        end
    end

    assign STAT_HIT  = r_stat_hit;
    assign STAT_MISS = r_stat_miss;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_dm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dcache_dm
// Brief    : Directed self-checking bench for dcache_dm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_dm;

    logic        CLK = 1'b0;
    logic        RST_X = 1'b0;
    logic        OE = 1'b0;
    logic [31:0] ADDR = '0;
    logic [31:0] WDATA = '0;
    logic [3:0]  WE = '0;
    logic        HIT;
    logic        MISS;
    logic [31:0] RDATA;
    logic        FILL_VALID = 1'b0;
    logic [31:0] FILL_DATA = '0;
    logic        INV = 1'b0;
    logic        BUSY;
`ifdef DCACHE_STAT_EN
    logic [31:0] STAT_HIT;
    logic [31:0] STAT_MISS;
`endif

    int n_pass  = 0;
    int n_total = 0;

    dcache_dm dut (
        .CLK        (CLK),
        .RST_X      (RST_X),
        .OE         (OE),
        .ADDR       (ADDR),
        .WDATA      (WDATA),
        .WE         (WE),
        .HIT        (HIT),
        .MISS       (MISS),
        .RDATA      (RDATA),
        .FILL_VALID (FILL_VALID),
        .FILL_DATA  (FILL_DATA),
        .INV        (INV),
        .BUSY       (BUSY)
`ifdef DCACHE_STAT_EN
        ,
        .STAT_HIT   (STAT_HIT),
        .STAT_MISS  (STAT_MISS)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic rd_issue(input logic [31:0] a);
        OE = 1'b1; ADDR = a; WE = 4'b0000;
        tick();
        OE = 1'b0;
    endtask

    task automatic wr_issue(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        OE = 1'b1; ADDR = a; WE = be; WDATA = d;
        tick();
        OE = 1'b0; WE = 4'b0000;
    endtask

    task automatic do_fill(input logic [31:0] d);
        FILL_VALID = 1'b1; FILL_DATA = d;
        tick();
        FILL_VALID = 1'b0;
    endtask

    task automatic test_reset;
        RST_X = 1'b0;
        repeat (3) tick();
        n_total++; if (HIT !== 1'b0) $display("FAIL reset.hit: got %b want 0", HIT); else n_pass++;
        n_total++; if (MISS !== 1'b0) $display("FAIL reset.miss: got %b want 0", MISS); else n_pass++;
        n_total++; if (RDATA !== 32'h0) $display("FAIL reset.rdata: got %h want 00000000", RDATA); else n_pass++;
        n_total++; if (BUSY !== 1'b0) $display("FAIL reset.busy: got %b want 0", BUSY); else n_pass++;
        RST_X = 1'b1;
        tick();
    endtask

    task automatic test_miss_fill;
        rd_issue(32'h0000_0100);
        n_total++; if (MISS !== 1'b1) $display("FAIL miss_fill.miss: got %b want 1", MISS); else n_pass++;
        n_total++; if (HIT !== 1'b0) $display("FAIL miss_fill.hit: got %b want 0", HIT); else n_pass++;
        n_total++; if (BUSY !== 1'b1) $display("FAIL miss_fill.busy: got %b want 1", BUSY); else n_pass++;
        tick();
        n_total++; if (MISS !== 1'b0) $display("FAIL miss_fill.miss_pulse: got %b want 0", MISS); else n_pass++;
        n_total++; if (BUSY !== 1'b1) $display("FAIL miss_fill.busy_wait: got %b want 1", BUSY); else n_pass++;
        tick();
        tick();
        do_fill(32'h1234_5678);
        n_total++; if (BUSY !== 1'b0) $display("FAIL miss_fill.busy_drop: got %b want 0", BUSY); else n_pass++;
        rd_issue(32'h0000_0100);
        n_total++; if (HIT !== 1'b1) $display("FAIL miss_fill.rehit: got %b want 1", HIT); else n_pass++;
        n_total++; if (RDATA !== 32'h1234_5678) $display("FAIL miss_fill.rdata: got %h want 12345678", RDATA); else n_pass++;
    endtask

    task automatic test_write_forward;
        wr_issue(32'h0000_0100, 4'b0010, 32'h0000_AB00);
        n_total++; if ((HIT !== 1'b0) || (MISS !== 1'b0)) $display("FAIL fwd.write_flags: got hit=%b miss=%b want 0 0", HIT, MISS); else n_pass++;
        rd_issue(32'h0000_0100);
        n_total++; if (HIT !== 1'b1) $display("FAIL fwd.hit: got %b want 1", HIT); else n_pass++;
        n_total++; if (RDATA !== 32'h1234_AB78) $display("FAIL fwd.rdata: got %h want 1234ab78", RDATA); else n_pass++;
        tick();
        n_total++; if (HIT !== 1'b0) $display("FAIL fwd.hit_clear: got %b want 0", HIT); else n_pass++;
        n_total++; if (RDATA !== 32'h1234_AB78) $display("FAIL fwd.rdata_hold: got %h want 1234ab78", RDATA); else n_pass++;
        rd_issue(32'h0000_0100);
        n_total++; if (RDATA !== 32'h1234_AB78 || HIT !== 1'b1) $display("FAIL fwd.reread: got hit=%b %h want 1 1234ab78", HIT, RDATA); else n_pass++;
    endtask

    task automatic test_back_to_back;
        wr_issue(32'h0000_0100, 4'b0001, 32'h0000_00CD);
        wr_issue(32'h0000_0100, 4'b1000, 32'hEF00_0000);
        rd_issue(32'h0000_0100);
        n_total++; if (HIT !== 1'b1) $display("FAIL b2b.hit: got %b want 1", HIT); else n_pass++;
        n_total++; if (RDATA !== 32'hEF34_ABCD) $display("FAIL b2b.rdata: got %h want ef34abcd", RDATA); else n_pass++;
    endtask

    task automatic test_no_write_alloc;
        wr_issue(32'h0000_0200, 4'hF, 32'hDEAD_BEEF);
        n_total++; if ((HIT !== 1'b0) || (MISS !== 1'b0)) $display("FAIL nwa.write_flags: got hit=%b miss=%b want 0 0", HIT, MISS); else n_pass++;
        tick();
        rd_issue(32'h0000_0200);
        n_total++; if (MISS !== 1'b1) $display("FAIL nwa.miss: got %b want 1", MISS); else n_pass++;
        tick();
        do_fill(32'h0000_0055);
        tick();
    endtask

    task automatic test_conflict;
        rd_issue(32'h0000_1100);
        n_total++; if (MISS !== 1'b1) $display("FAIL conflict.miss: got %b want 1", MISS); else n_pass++;
        tick();
        do_fill(32'hCAFE_BABE);
        rd_issue(32'h0000_1100);
        n_total++; if ((HIT !== 1'b1) || (RDATA !== 32'hCAFE_BABE)) $display("FAIL conflict.hit: got hit=%b %h want 1 cafebabe", HIT, RDATA); else n_pass++;
        rd_issue(32'h0000_0100);
        n_total++; if ((MISS !== 1'b1) || (HIT !== 1'b0)) $display("FAIL conflict.evict: got miss=%b hit=%b want 1 0", MISS, HIT); else n_pass++;
        tick();
        do_fill(32'hEF34_ABCD);
    endtask

    task automatic test_inv_idle;
        OE = 1'b1; ADDR = 32'h0000_0100; WE = 4'b0000; INV = 1'b1;
        tick();
        OE = 1'b0; INV = 1'b0;
        n_total++; if ((HIT !== 1'b1) || (RDATA !== 32'hEF34_ABCD)) $display("FAIL inv_idle.preclear: got hit=%b %h want 1 ef34abcd", HIT, RDATA); else n_pass++;
        rd_issue(32'h0000_0200);
        n_total++; if (MISS !== 1'b1) $display("FAIL inv_idle.cleared: got %b want 1", MISS); else n_pass++;
        tick();
        do_fill(32'h0000_0066);
    endtask

    task automatic test_inv_pending;
        rd_issue(32'h0000_0300);
        n_total++; if (MISS !== 1'b1) $display("FAIL inv_pend.miss: got %b want 1", MISS); else n_pass++;
        tick();
        INV = 1'b1;
        tick();
        INV = 1'b0;
        n_total++; if (BUSY !== 1'b1) $display("FAIL inv_pend.busy: got %b want 1", BUSY); else n_pass++;
        do_fill(32'h0000_0077);
        n_total++; if (BUSY !== 1'b0) $display("FAIL inv_pend.busy_drop: got %b want 0", BUSY); else n_pass++;
        tick();
`ifdef DCACHE_STAT_EN
        n_total++; if (STAT_HIT !== 32'd0) $display("FAIL inv_pend.stat_hit: got %0d want 0", STAT_HIT); else n_pass++;
        n_total++; if (STAT_MISS !== 32'd0) $display("FAIL inv_pend.stat_miss: got %0d want 0", STAT_MISS); else n_pass++;
`endif
        rd_issue(32'h0000_0300);
        n_total++; if ((MISS !== 1'b1) || (HIT !== 1'b0)) $display("FAIL inv_pend.filled_invalid: got miss=%b hit=%b want 1 0", MISS, HIT); else n_pass++;
        tick();
        do_fill(32'h0000_0088);
    endtask

    task automatic test_reset_mid_miss;
        rd_issue(32'h0000_1200);
        n_total++; if (MISS !== 1'b1) $display("FAIL rst_mid.miss: got %b want 1", MISS); else n_pass++;
        tick();
        #2;
        RST_X = 1'b0;
        #1;
        n_total++; if (BUSY !== 1'b0) $display("FAIL rst_mid.busy: got %b want 0", BUSY); else n_pass++;
        tick();
        RST_X = 1'b1;
        tick();
        do_fill(32'h0000_0099);
        n_total++; if (BUSY !== 1'b0) $display("FAIL rst_mid.fill_ignored: got busy=%b want 0", BUSY); else n_pass++;
        rd_issue(32'h0000_0300);
        n_total++; if ((MISS !== 1'b1) || (HIT !== 1'b0)) $display("FAIL rst_mid.all_invalid: got miss=%b hit=%b want 1 0", MISS, HIT); else n_pass++;
        tick();
        do_fill(32'h0000_0000);
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_write_forward();
        test_back_to_back();
        test_no_write_alloc();
        test_conflict();
        test_inv_idle();
        test_inv_pending();
        test_reset_mid_miss();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
